// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types, constants and register-match helper for the
//          branch hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        BR_LD2 = 1'b1
    } haz_state_t;

    localparam int         REG_W          = 5;
    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MD_LATENCY_DEF = 4;

    // $zero is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic             regwrite,
                                       input logic [REG_W-1:0] wreg,
                                       input logic [REG_W-1:0] src);
        return regwrite && (wreg == src) && (src != REG_ZERO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_counter.sv
// ============================================================================
// Module : md_busy_counter
// Brief  : Down-counter tracking how long the mult/div unit stays occupied.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_busy_counter #(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam int CW = 4;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= CW'(LATENCY);
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign busy = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
// ============================================================================
// Module : branch_hazard_ctrl
// Brief  : Decode-stage stall/forward/branch-resolve control for a 5-stage
//          pipeline. Optional stall statistics counter under HAZ_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_branch,
    input  logic             id_bne,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             cmp_equal,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             mem_regwrite,
    input  logic             mem_memtoreg,
    input  logic [REG_W-1:0] mem_wreg,
    input  logic             id_md_start,
    input  logic             id_md_read,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             flush_d,
    output logic             branch_taken,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             md_busy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    haz_state_t r_state;
    haz_state_t w_state_next;
    logic       w_fsm_stall;

    logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
    logic w_load_use, w_br_alu, w_br_ld, w_br_ld_mem, w_md_stall;
    logic w_stall, w_md_start;

    assign w_rs_ex  = reg_match(ex_regwrite,  ex_wreg,  id_rs);
    assign w_rt_ex  = reg_match(ex_regwrite,  ex_wreg,  id_rt);
    assign w_rs_mem = reg_match(mem_regwrite, mem_wreg, id_rs);
    assign w_rt_mem = reg_match(mem_regwrite, mem_wreg, id_rt);

    assign fwd_a_d = w_rs_mem & ~mem_memtoreg;
    assign fwd_b_d = w_rt_mem & ~mem_memtoreg;

    // The branch comparator reads both rs and rt regardless of id_uses_rt.
    assign w_load_use  = ex_memtoreg & (w_rs_ex | (id_uses_rt & w_rt_ex));
    assign w_br_alu    = id_branch & ~ex_memtoreg & (w_rs_ex | w_rt_ex);
    assign w_br_ld     = id_branch &  ex_memtoreg & (w_rs_ex | w_rt_ex);
    assign w_br_ld_mem = id_branch & mem_memtoreg & (w_rs_mem | w_rt_mem)
                         & (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_br_ld) w_state_next = BR_LD2;
            BR_LD2:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_fsm_stall = 1'b0;
        case (r_state)
            BR_LD2:  w_fsm_stall = 1'b1;
            default: w_fsm_stall = 1'b0;
        endcase
    end

    assign w_md_stall = (id_md_start | id_md_read) & md_busy;
    assign w_stall    = w_load_use | w_br_alu | w_br_ld | w_br_ld_mem
                        | w_fsm_stall | w_md_stall;
    // A start is only accepted when the instruction actually leaves decode.
    assign w_md_start = id_md_start & ~w_stall & ~md_busy;

    md_busy_counter #(
        .LATENCY (MD_LATENCY)
    ) u_md_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (w_md_start),
        .busy  (md_busy)
    );

    assign stall_f      = w_stall;
    assign stall_d      = w_stall;
    assign flush_e      = w_stall;
    assign branch_taken = id_branch & ~w_stall & (cmp_equal ^ id_bne);
    assign flush_d      = branch_taken;

`ifdef HAZ_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
// ============================================================================
// Module : tb_branch_hazard_ctrl
// Brief  : Scoreboard bench: directed scenarios plus random decode/pipeline
//          traffic checked against a cycle-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_hazard_ctrl;

    localparam int LAT = 4;

    typedef struct packed {
        logic       reset;
        logic       branch, bne, uses_rt, cmp;
        logic [4:0] rs, rt;
        logic       ex_rw, ex_m2r;
        logic [4:0] ex_w;
        logic       mem_rw, mem_m2r;
        logic [4:0] mem_w;
        logic       md_start, md_read;
    } stim_t;

    typedef struct packed {
        logic        stall, taken, fa, fb, busy;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic id_branch, id_bne, id_uses_rt, cmp_equal;
    logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
    logic ex_regwrite, ex_memtoreg, mem_regwrite, mem_memtoreg;
    logic id_md_start, id_md_read;
    logic stall_f, stall_d, flush_e, flush_d, branch_taken, fwd_a_d, fwd_b_d, md_busy;
`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt;
`endif

    branch_hazard_ctrl #(.MD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .id_branch(id_branch), .id_bne(id_bne), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .cmp_equal(cmp_equal),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_wreg(ex_wreg),
        .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_wreg(mem_wreg),
        .id_md_start(id_md_start), .id_md_read(id_md_read),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .flush_d(flush_d),
        .branch_taken(branch_taken), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .md_busy(md_busy)
`ifdef HAZ_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    // Reference model state: remaining forced branch-load cycles, cycle index
    // at which the mult/div unit becomes free, and the stall tally.
    int          m_extra    = 0;
    int          m_cyc      = 0;
    int          m_md_free  = 0;
    logic [31:0] m_cnt      = 0;
    stim_t       m_cur;
    logic        m_cur_stall, m_cur_brld, m_cur_start, m_have_cur = 1'b0;

    function automatic logic dep(input logic rw, input logic [4:0] w, input logic [4:0] r);
        return rw && (w == r) && (r != 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One decode cycle: retire the previous cycle into the model, apply the
    // new inputs and queue what the DUT should show during this cycle.
    task automatic step(input stim_t s);
        exp_t e;
        logic rs_ex, rt_ex, rs_mem, rt_mem, busy, lu, bal, bld, bmem;
        @(posedge clk);
        if (m_have_cur) begin
            if (m_cur.reset) begin
                m_extra = 0; m_md_free = 0; m_cnt = 0;
            end else begin
                if (m_cur_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_extra > 0) m_extra = m_extra - 1;
                else if (m_cur_brld) m_extra = 1;
                if (m_cur_start) m_md_free = m_cyc + 1 + LAT;
            end
            m_cyc++;
        end
        #1;
        reset = s.reset; id_branch = s.branch; id_bne = s.bne; id_uses_rt = s.uses_rt;
        cmp_equal = s.cmp; id_rs = s.rs; id_rt = s.rt;
        ex_regwrite = s.ex_rw; ex_memtoreg = s.ex_m2r; ex_wreg = s.ex_w;
        mem_regwrite = s.mem_rw; mem_memtoreg = s.mem_m2r; mem_wreg = s.mem_w;
        id_md_start = s.md_start; id_md_read = s.md_read;

        rs_ex  = dep(s.ex_rw, s.ex_w, s.rs);   rt_ex  = dep(s.ex_rw, s.ex_w, s.rt);
        rs_mem = dep(s.mem_rw, s.mem_w, s.rs); rt_mem = dep(s.mem_rw, s.mem_w, s.rt);
        busy = (m_cyc < m_md_free);
        lu   = s.ex_m2r && (rs_ex || (s.uses_rt && rt_ex));
        bal  = s.branch && !s.ex_m2r && (rs_ex || rt_ex);
        bld  = s.branch &&  s.ex_m2r && (rs_ex || rt_ex);
        bmem = s.branch && s.mem_m2r && (rs_mem || rt_mem) && (m_extra == 0);
        e.stall = lu || bal || bld || bmem || (m_extra > 0)
                  || ((s.md_start || s.md_read) && busy);
        e.taken = s.branch && !e.stall && (s.cmp != s.bne);
        e.fa    = rs_mem && !s.mem_m2r;
        e.fb    = rt_mem && !s.mem_m2r;
        e.busy  = busy;
        e.cnt   = m_cnt;
        if (m_have_cur || s.reset == 1'b0) sb_q.push_back(e);
        m_cur = s; m_cur_stall = e.stall; m_cur_brld = bld && (m_extra == 0);
        m_cur_start = s.md_start && !e.stall && !busy;
        m_have_cur = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("stall_d", 32'(stall_d), 32'(e.stall));
                chk("stall_f", 32'(stall_f), 32'(e.stall));
                chk("flush_e", 32'(flush_e), 32'(e.stall));
                chk("branch_taken", 32'(branch_taken), 32'(e.taken));
                chk("flush_d", 32'(flush_d), 32'(e.taken));
                chk("fwd_a_d", 32'(fwd_a_d), 32'(e.fa));
                chk("fwd_b_d", 32'(fwd_b_d), 32'(e.fb));
                chk("md_busy", 32'(md_busy), 32'(e.busy));
`ifdef HAZ_STATS_EN
                chk("stall_cnt", stall_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin : driver
        stim_t z, s;
        int    waited;
        z = '0;
        s = z; s.reset = 1'b1;
        // First cycle: DUT state undefined until the reset edge, not queued.
        m_have_cur = 1'b0;
        @(negedge clk);
        reset = 1'b1; id_branch = 0; id_bne = 0; id_uses_rt = 0; cmp_equal = 0;
        id_rs = 0; id_rt = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_wreg = 0;
        mem_regwrite = 0; mem_memtoreg = 0; mem_wreg = 0; id_md_start = 0; id_md_read = 0;
        m_cur = s; m_cur_stall = 0; m_cur_brld = 0; m_cur_start = 0; m_have_cur = 1'b1;
        step(z);                                   // reset state, inputs zero

        // Branch on rs with an EX ALU writer, then MEM forward.
        s = z; s.branch = 1; s.rs = 5; s.ex_rw = 1; s.ex_w = 5; step(s);
        s = z; s.branch = 1; s.rs = 5; s.mem_rw = 1; s.mem_w = 5; s.cmp = 1; step(s);
        step(z);
        // Branch with an EX load on rt=7: two stall cycles.
        s = z; s.branch = 1; s.rt = 7; s.uses_rt = 1; s.ex_rw = 1; s.ex_m2r = 1; s.ex_w = 7;
        step(s);
        s = z; s.branch = 1; s.rt = 7; s.uses_rt = 1; s.mem_rw = 1; s.mem_m2r = 1; s.mem_w = 7;
        step(s);
        s = z; s.branch = 1; s.rt = 7; s.uses_rt = 1; step(s);
        // beq taken, bne not taken; $zero never matches.
        s = z; s.branch = 1; s.cmp = 1; step(s);
        s.bne = 1; step(s);
        s = z; s.ex_rw = 1; s.ex_m2r = 1; s.mem_rw = 1; s.branch = 1; step(s);
        // Mult/div start then reads for five cycles.
        s = z; s.md_start = 1; step(s);
        s = z; s.md_read = 1;
        for (int i = 0; i < 5; i++) step(s);
        // Reset during BR_LD2 with the counter at 2.
        s = z; s.md_start = 1; step(s);
        step(z);
        s = z; s.branch = 1; s.rs = 3; s.ex_rw = 1; s.ex_m2r = 1; s.ex_w = 3; step(s);
        s = z; s.reset = 1; step(s);
        s = z; s.md_read = 1; step(s);
        s = z; s.reset = 1; step(s);

        for (int i = 0; i < 600; i++) begin
            s.reset    = ($urandom_range(0, 99) < 3);
            s.branch   = ($urandom_range(0, 99) < 40);
            s.bne      = 1'($urandom);
            s.uses_rt  = 1'($urandom);
            s.cmp      = 1'($urandom);
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.ex_rw    = 1'($urandom);
            s.ex_m2r   = 1'($urandom);
            s.ex_w     = 5'($urandom_range(0, 3));
            s.mem_rw   = 1'($urandom);
            s.mem_m2r  = 1'($urandom);
            s.mem_w    = 5'($urandom_range(0, 3));
            s.md_start = ($urandom_range(0, 99) < 15);
            s.md_read  = ($urandom_range(0, 99) < 15);
            step(s);
        end
        step(z);

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 4: mult/div busy cycles after issue (range 2..15).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be clk and reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 id_branch, id_bne  input  1 each  decode holds beq (id_bne=0) or bne (id_bne=1).
REQ-006 id_rs, id_rt  input  5 each  decode source registers; id_uses_rt input 1 marks rt as read.
REQ-007 cmp_equal  input  1  equality result from the decode-stage comparator.
REQ-008 ex_regwrite, ex_memtoreg  input  1 each; ex_wreg  input  5  EX-stage destination.
REQ-009 mem_regwrite, mem_memtoreg  input  1 each; mem_wreg  input  5  MEM-stage destination.
REQ-010 id_md_start, id_md_read  input  1 each  decode issues mult/div, or mfhi/mflo.
REQ-011 stall_f, stall_d, flush_e  output  1 each  freeze IF/ID and insert EX bubble.
REQ-012 flush_d  output  1  squash the IF/ID instruction.
REQ-013 branch_taken  output  1  redirect the PC to the branch target.
REQ-014 fwd_a_d, fwd_b_d  output  1 each  select the MEM ALU result for comparator in0 or in1.
REQ-015 md_busy  output  1  mult/div unit is occupied.

Function
REQ-016 Register 0 SHALL never match; a match requires the writer's regwrite=1 and an equal 5-bit register number.
REQ-017 fwd_a_d SHALL be 1 iff id_rs matches mem_wreg with mem_memtoreg=0; fwd_b_d likewise on id_rt. Both are combinational.
REQ-018 Load-use hazard: ex_memtoreg=1 and ex_wreg matches id_rs, or matches id_rt when id_uses_rt=1; this SHALL stall for one cycle.
REQ-019 Branch-ALU hazard: id_branch=1 and an EX ALU writer (memtoreg=0) matches rs or rt; this SHALL stall for one cycle.
REQ-020 Branch-load hazard: id_branch=1 and an EX load matches; this SHALL stall for two cycles.
REQ-021 FSM states: IDLE and BR_LD2. IDLE goes to BR_LD2 on a branch-load hazard. BR_LD2 asserts stall unconditionally and returns to IDLE after one cycle.
REQ-022 Branch-load in MEM (mem_memtoreg match while id_branch=1 in IDLE) SHALL stall for one cycle.
REQ-023 MD counter: on id_md_start=1 with stall=0 and the counter at 0, the counter SHALL load MD_LATENCY. It SHALL decrement each cycle while nonzero. md_busy = (counter!=0).
REQ-024 id_md_start or id_md_read while md_busy=1 SHALL stall.
REQ-025 stall = OR of all stall sources. stall_f = stall_d = flush_e = stall.
REQ-026 branch_taken = id_branch & ~stall & (cmp_equal ^ id_bne). flush_d = branch_taken.
REQ-027 Simultaneous hazards: all sources are ORed. The FSM and the counter advance independently, and neither blocks the other.

Reset
REQ-028 While reset=1 at a clk edge, the FSM SHALL go to IDLE and the counter to 0. All outputs SHALL be 0 in the following cycle, provided the inputs are 0.
REQ-029 Reset in the middle of a BR_LD2 stall or an MD countdown SHALL abort it with no residual stall.

Configuration
REQ-030 When HAZ_STATS_EN is defined, an output stall_cnt (32 bits) SHALL count cycles with stall_d=1. It SHALL saturate at 0xFFFFFFFF and clear on reset.
REQ-031 When HAZ_STATS_EN is undefined, the stall_cnt port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Package hazard_pkg SHALL hold typedef haz_state_t {IDLE, BR_LD2}, REG_ZERO=5'd0, REG_W=5 and MD_LATENCY_DEF=4.
REQ-033 The MD down-counter SHALL be the sub-module md_busy_counter, with ports clk, reset, start, busy.

Verification
REQ-034 id_branch=1, id_rs=5, ex_regwrite=1, ex_wreg=5, ex_memtoreg=0 -> stall one cycle; next cycle mem_wreg=5 gives fwd_a_d=1, stall=0.
REQ-035 Branch with an EX load to rt=7 (id_uses_rt=1) -> stall_d=1 for exactly two cycles; the FSM passes through BR_LD2 back to IDLE.
REQ-036 beq with cmp_equal=1 and no hazard -> branch_taken=1, flush_d=1; bne with cmp_equal=1 -> both 0.
REQ-037 id_md_start at t0, MD_LATENCY=4, id_md_read at t1..t5 -> stall asserted t1..t4, released at t5.
REQ-038 Assert reset during the second BR_LD2 cycle and during a countdown at value 2 -> next cycle stall=0, md_busy=0.
REQ-039 With HAZ_STATS_EN: after scenarios REQ-034 and REQ-035, stall_cnt=3; id_rs=0 with ex_wreg=0 -> no stall, no forward.
